// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared MMIO offsets and STATUS bit positions
// Used by the responder RTL and by the processor-side test programs.
package dmem_responder_pkg;

   // MMIO register word offsets from MMIO_BASE
   localparam int unsigned MMIO_LED    = 0;
   localparam int unsigned MMIO_TXDATA = 1;
   localparam int unsigned MMIO_STATUS = 2;
   localparam int unsigned MMIO_CYCLE  = 3;

   // STATUS register bit positions
   localparam int unsigned STAT_EMPTY     = 0;
   localparam int unsigned STAT_FULL      = 1;
   localparam int unsigned STAT_OVERFLOW  = 2;
   localparam int unsigned STAT_COUNT_LSB = 8;

   function automatic logic [31:0] statusWord(input logic        empty,
                                              input logic        full,
                                              input logic        overflow,
                                              input logic [31:0] count);
      logic [31:0] w;
      w = count << STAT_COUNT_LSB;
      w[STAT_EMPTY]    = empty;
      w[STAT_FULL]     = full;
      w[STAT_OVERFLOW] = overflow;
      return w;
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - first-word fall-through byte FIFO for the TX drain path
// Ports: clock, reset (async, active-high), push/pushData (write side),
//        pop (read side, ignored when empty), full, empty, count (0..depth),
//        head (front entry, 0 when empty).
module tx_fifo #(
   parameter int WIDTH     = 8,
   parameter int FIFO_LOG2 = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     pushData,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [FIFO_LOG2:0]   count,
   output logic [WIDTH-1:0]     head
);

   logic [WIDTH-1:0]     mem [0:(1<<FIFO_LOG2)-1];
   logic [FIFO_LOG2-1:0] rdPtr;
   logic [FIFO_LOG2-1:0] wrPtr;
   logic                 popOk;
   logic                 pushOk;

   // count never exceeds depth, so its MSB alone marks full
   assign full   = count[FIFO_LOG2];
   assign empty  = (count == '0);
   assign popOk  = pop && !empty;
   // when full, a same-edge pop frees the slot the push lands in
   assign pushOk = push && (!full || popOk);
   assign head   = empty ? '0 : mem[rdPtr];

   always_ff @(posedge clock) begin
      if (pushOk) mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + 1'b1;
         if (popOk)  rdPtr <= rdPtr + 1'b1;
         if (pushOk && !popOk)      count <= count + 1'b1;
         else if (popOk && !pushOk) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus LED/TX/STATUS/CYCLE MMIO
// Ports: clock, reset (async, active-high); address_dmem/data/wren from the
//        processor, q_dmem registered read data; led_out LED register;
//        tx_data/tx_valid/tx_ready TX byte drain.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] MMIO_BASE = 32'h0000_F000,
   parameter int          FIFO_LOG2 = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic [15:0] led_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   logic [31:0] ram [0:(1<<ADDR_BITS)-1];

   logic               ramSel, ledSel, txSel, statusSel, cycleSel;
   logic               fifoFull, fifoEmpty, txPop, txPush, overflowEvt;
   logic [FIFO_LOG2:0] fifoCount;
   logic               overflow;
   logic [31:0]        cycleCnt;
   logic [31:0]        readMux;

   assign ramSel    = (address_dmem[31:ADDR_BITS] == '0);
   assign ledSel    = (address_dmem == MMIO_BASE + MMIO_LED);
   assign txSel     = (address_dmem == MMIO_BASE + MMIO_TXDATA);
   assign statusSel = (address_dmem == MMIO_BASE + MMIO_STATUS);
   assign cycleSel  = (address_dmem == MMIO_BASE + MMIO_CYCLE);

   assign tx_valid    = !fifoEmpty;
   assign txPop       = tx_valid && tx_ready;
   assign txPush      = wren && txSel;
   // full implies non-empty, so only a same-edge pop can save the byte
   assign overflowEvt = txPush && fifoFull && !txPop;

   tx_fifo #(.WIDTH(8), .FIFO_LOG2(FIFO_LOG2)) u_txFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (txPush),
      .pushData (data[7:0]),
      .pop      (tx_ready),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount),
      .head     (tx_data)
   );

   // All reads see pre-edge state, which gives read-first RAM behaviour
   always_comb begin
      readMux = '0;
      if (ramSel)         readMux = ram[address_dmem[ADDR_BITS-1:0]];
      else if (ledSel)    readMux = {16'b0, led_out};
      else if (statusSel) readMux = statusWord(fifoEmpty, fifoFull, overflow, 32'(fifoCount));
      else if (cycleSel)  readMux = cycleCnt;
   end

   always_ff @(posedge clock) begin
      if (wren && ramSel) ram[address_dmem[ADDR_BITS-1:0]] <= data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_dmem   <= '0;
         led_out  <= '0;
         overflow <= 1'b0;
         cycleCnt <= '0;
      end else begin
         q_dmem <= readMux;
         if (wren && ledSel) led_out <= data[15:0];
         // read-to-clear, but a same-edge overflow wins
         if (overflowEvt)     overflow <= 1'b1;
         else if (statusSel)  overflow <= 1'b0;
         if (wren && cycleSel) cycleCnt <= data;
         else                  cycleCnt <= cycleCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'h0000_F000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [15:0] led_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int vectors = 0;
   int miscompares = 0;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .led_out      (led_out),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // called at a falling edge: drive inputs, let one rising edge pass, return at next falling edge
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
      address_dmem = a;
      data         = d;
      wren         = w;
      @(negedge clock);
   endtask

   logic [7:0] drainExp [8];

   initial begin
      reset = 1'b1; address_dmem = '0; data = '0; wren = 1'b0; tx_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // reset state
      check("rst_q", q_dmem, 32'h0);
      check("rst_led", {16'b0, led_out}, 32'h0);
      check("rst_valid", {31'b0, tx_valid}, 32'h0);
      check("rst_txdata", {24'b0, tx_data}, 32'h0);
      cyc(BASE + 3, 0, 1'b0);
      check("cycle_start0", q_dmem, 32'h0);
      cyc(BASE + 3, 0, 1'b0);
      check("cycle_start1", q_dmem, 32'h1);
      cyc(BASE + 2, 0, 1'b0);
      check("rst_status", q_dmem, 32'h0000_0001);

      // 1: RAM write/read and read-first
      cyc(5, 32'hDEAD_BEEF, 1'b1);
      cyc(5, 0, 1'b0);
      check("ram_rd", q_dmem, 32'hDEAD_BEEF);
      cyc(5, 32'h1, 1'b1);
      check("ram_readfirst", q_dmem, 32'hDEAD_BEEF);
      cyc(5, 0, 1'b0);
      check("ram_new", q_dmem, 32'h1);

      // 2: LED and unmapped
      cyc(BASE + 0, 32'h0001_ABCD, 1'b1);
      check("led_out", {16'b0, led_out}, 32'h0000_ABCD);
      cyc(BASE + 0, 0, 1'b0);
      check("led_rd", q_dmem, 32'h0000_ABCD);
      cyc(BASE + 7, 32'hFFFF_FFFF, 1'b1);
      check("unmapped_rd", q_dmem, 32'h0);
      cyc(BASE + 1, 0, 1'b0);
      check("txdata_rd", q_dmem, 32'h0);
      check("txrd_nopush", {31'b0, tx_valid}, 32'h0);

      // 3: fill and overflow
      for (int i = 0; i < 9; i++) cyc(BASE + 1, 32'h10 + i, 1'b1);
      check("full_head", {24'b0, tx_data}, 32'h10);
      check("full_valid", {31'b0, tx_valid}, 32'h1);
      cyc(BASE + 2, 0, 1'b0);
      check("status_ovf", q_dmem, 32'h0000_0806);
      cyc(BASE + 2, 0, 1'b0);
      check("status_clr", q_dmem, 32'h0000_0802);

      // 4: push into full FIFO with simultaneous pop, then drain
      tx_ready = 1'b1;
      cyc(BASE + 1, 32'h55, 1'b1);
      tx_ready = 1'b0;
      cyc(BASE + 2, 0, 1'b0);
      check("status_pushpop", q_dmem, 32'h0000_0802);
      check("head_after_pop", {24'b0, tx_data}, 32'h11);
      drainExp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_valid%0d", i), {31'b0, tx_valid}, 32'h1);
         check($sformatf("drain_data%0d", i), {24'b0, tx_data}, {24'b0, drainExp[i]});
         cyc(0, 0, 1'b0);
      end
      check("drain_valid_end", {31'b0, tx_valid}, 32'h0);
      check("drain_data_end", {24'b0, tx_data}, 32'h0);
      tx_ready = 1'b0;

      // 5: CYCLE load and wrap
      cyc(BASE + 3, 32'hFFFF_FFFE, 1'b1);
      cyc(BASE + 3, 0, 1'b0);
      check("cycle0", q_dmem, 32'hFFFF_FFFE);
      cyc(BASE + 3, 0, 1'b0);
      check("cycle1", q_dmem, 32'hFFFF_FFFF);
      cyc(BASE + 3, 0, 1'b0);
      check("cycle_wrap", q_dmem, 32'h0);

      // 6: async reset mid-drain
      cyc(9, 32'h1234_5678, 1'b1);
      cyc(BASE + 0, 32'h5A5A, 1'b1);
      for (int i = 0; i < 4; i++) cyc(BASE + 1, 32'hA1 + i, 1'b1);
      tx_ready = 1'b1;
      cyc(9, 0, 1'b0);
      check("pre_rst_q", q_dmem, 32'h1234_5678);
      check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
      check("pre_rst_head", {24'b0, tx_data}, 32'hA2);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", {31'b0, tx_valid}, 32'h0);
      check("arst_q", q_dmem, 32'h0);
      check("arst_led", {16'b0, led_out}, 32'h0);
      check("arst_txdata", {24'b0, tx_data}, 32'h0);
      #1 reset = 1'b0;
      tx_ready = 1'b0;
      cyc(9, 0, 1'b0);
      check("ram_kept", q_dmem, 32'h1234_5678);
      cyc(BASE + 2, 0, 1'b0);
      check("status_after_rst", q_dmem, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory interface: services `address_dmem`, `data` and `wren`, and returns `q_dmem`.
- Contains word-addressed data RAM plus a small memory-mapped I/O (MMIO) region: LED register, TX byte FIFO with ready/valid drain, status register and a free-running cycle counter.
- Sits in the wrapper beside the processor, replacing a bare RAM instance.

Parameters:
- `ADDR_BITS`, 12, log2 of RAM depth in 32-bit words (RAM occupies word addresses 0 .. 2^ADDR_BITS-1).
- `MMIO_BASE`, 32'h0000_F000, word address of the first MMIO register.
- `FIFO_LOG2`, 3, log2 of TX FIFO depth (default 8 entries).

Ports:
- `clock` in 1: master clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `address_dmem` in 32: word address from the processor.
- `data` in 32: store data.
- `wren` in 1: store enable.
- `q_dmem` out 32: registered read data.
- `led_out` out 16: LED register contents.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: consumer accepts the head byte.

Behaviour:
- Reset (async): `q_dmem`=0, `led_out`=0, FIFO empty, `tx_valid`=0, `tx_data`=0, overflow flag=0, cycle counter=0. RAM contents are not cleared.
- Timing contract: the processor drives address/data/wren from its falling-edge registers. On each rising edge this block samples them and registers `q_dmem`. Read latency is exactly one rising edge, so `q_dmem` is stable before the processor's next falling edge.
- Address decode (word addresses):
  - addr < 2^ADDR_BITS: RAM.
  - MMIO_BASE+0: LED.
  - MMIO_BASE+1: TXDATA.
  - MMIO_BASE+2: STATUS.
  - MMIO_BASE+3: CYCLE.
  - Any other address: reads return 0, writes are ignored.
- RAM: a write stores `data` at the edge. Read-first: a read and write to the same address at the same edge returns the old word.
- LED: a write loads `data[15:0]`. A read returns {16'b0, led}.
- TXDATA write: pushes `data[7:0]`.
  - The push is accepted if the FIFO is not full, or if it is full and a pop occurs at the same edge.
  - Otherwise the byte is dropped and overflow is set.
  - A TXDATA read returns 0.
- STATUS read returns:
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow
  - bits[8+FIFO_LOG2:8] = occupancy count (0..depth)
  - all other bits 0.
- STATUS read-to-clear: a STATUS read clears overflow at that edge. If an overflow occurs at the same edge, set wins. STATUS writes are ignored.
- CYCLE: increments by 1 every edge and wraps at 2^32. A write loads `data` and takes priority over the increment. A read returns the pre-edge value.
- TX drain: `tx_valid` = !empty and `tx_data` = head byte (first-word fall-through).
  - A pop occurs when `tx_valid && tx_ready` at an edge.
  - `tx_data` is held stable while `tx_valid && !tx_ready`.
  - `tx_data` = 0 when empty.
- Simultaneous push and pop with the FIFO non-full and non-empty: count is unchanged and both pointers advance. Pointers wrap modulo depth.
- Reset asserted mid-stream empties the FIFO immediately. Bytes in flight are lost, and `tx_valid` drops asynchronously.
- `wren`=0 with a TXDATA address causes no push. `q_dmem` updates every edge regardless of `wren`.

Decomposition:
- Shared include header: MMIO offset localparams (LED=0, TXDATA=1, STATUS=2, CYCLE=3) and STATUS bit positions. The processor-side test programs use the same header.
- One sub-module, `tx_fifo`:
  - Parameters: width 8, FIFO_LOG2.
  - Signals: push/pop, full/empty/count, head.
  - Ports: `clock`, async active-high `reset`.
  - Implements the same push-when-full-with-pop rule.
- RAM is inferred inside `dmem_responder` as a plain reg array.

Test Plan:
1. Write 32'hDEAD_BEEF to addr 5, then read addr 5 → `q_dmem`=32'hDEAD_BEEF one edge after the read. Write 32'h1 to addr 5 and read addr 5 at the same edge → `q_dmem`=32'hDEAD_BEEF (old data).
2. Write 32'h0001_ABCD to MMIO_BASE+0 → `led_out`=16'hABCD. Read MMIO_BASE+0 → 32'h0000_ABCD. Read MMIO_BASE+7 → 0.
3. With `tx_ready`=0, push bytes 0x10..0x18 (9 writes) → STATUS reads full=1, overflow=1, count=8, `tx_data`=0x10. A second STATUS read → overflow=0.
4. FIFO full and `tx_ready`=1 while writing 0x55 at the same edge → no overflow, count stays 8. Draining all bytes yields 0x11..0x17 then 0x55 in order, and `tx_valid` falls after the last pop.
5. Write 32'hFFFF_FFFE to CYCLE, then read on the following edges → 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000 (wrap).
6. Assert `reset` asynchronously mid-drain with 3 bytes queued → `tx_valid`=0, `q_dmem`=0, `led_out`=0 before the next edge. A RAM word written before reset still reads back unchanged.
